// File: rtl/eth_rx_buf_pkg.sv
// Shared types and constants for the Ethernet RX frame buffer: write-FSM states,
// CSR word addresses and STATUS/CONTROL bit positions.
package eth_rx_buf_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } wr_state_e;

    localparam logic [1:0] CSR_STATUS  = 2'd0;
    localparam logic [1:0] CSR_DATA    = 2'd1;
    localparam logic [1:0] CSR_CONTROL = 2'd2;
    localparam logic [1:0] CSR_STATS   = 2'd3;

    localparam int LEN_W            = 16;
    localparam int STATUS_AVAIL_BIT = 31;
    localparam int STATUS_CNT_MSB   = 30;
    localparam int STATUS_CNT_LSB   = 28;
    localparam int CTRL_RELEASE_BIT = 0;
    localparam int CTRL_FLUSH_BIT   = 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rx_len_fifo.sv
// Queue of committed frame lengths; head is the oldest unreleased frame.
// Push and pop may coincide while full; flush empties the queue and wins over both.
module eth_rx_len_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_idx <= wr_idx + PTR_W'(1);
            if (do_pop)  rd_idx <= rd_idx + PTR_W'(1);
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_idx] <= push_data;
    end

endmodule

// File: rtl/eth_nios_v2_rx_frame_buf.sv
// Ethernet RX frame buffer: MAC byte stream into a ring RAM, drained frame by frame via Avalon-MM CSRs.
// Define ETH_RX_BUF_STATS_EN to build the saturating rx/drop frame counters behind the STATS word.
module eth_nios_v2_rx_frame_buf
    import eth_rx_buf_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 9,
    parameter int LEN_FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              in_err,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(LEN_FIFO_DEPTH) + 1;

    // Stream handshake: a byte is transferred on every cycle in_valid is high; there is
    // no ready, so a byte that cannot be stored takes its whole frame down with it.
    wr_state_e         state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] frm_start, frm_start_n;
    logic [ADDR_W-1:0] rd_base, rd_base_eff;
    logic [LEN_W-1:0]  rd_off;

    logic [LEN_W-1:0]  lenq_head, head_len, push_len;
    logic [CNT_W-1:0]  lenq_count;
    logic              lenq_full, lenq_empty, lenq_room, push;

    logic              ctrl_wr, stats_wr, rd_req, data_rd, data_ok;
    logic              flush_fire, release_fire;
    logic [ADDR_W-1:0] byte_base, byte_used, byte_len;
    logic              byte_full, mid_frame;
    logic              commit_inc, drop_inc, ram_we;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic [31:0]       status_word, stats_word, csr_word, rd_word_q;
    logic              data_ok_q;
    logic              unused_wdata;

    assign ctrl_wr      = chipselect && write && (address == CSR_CONTROL);
    assign stats_wr     = chipselect && write && (address == CSR_STATS);
    assign rd_req       = chipselect && read;
    assign data_rd      = rd_req && (address == CSR_DATA);
    assign flush_fire   = ctrl_wr && writedata[CTRL_FLUSH_BIT];
    assign release_fire = ctrl_wr && writedata[CTRL_RELEASE_BIT] && !writedata[CTRL_FLUSH_BIT] && !lenq_empty;
    assign unused_wdata = ^writedata[31:2];

    assign head_len    = lenq_empty ? '0 : lenq_head;
    assign rd_base_eff = release_fire ? rd_base + head_len[ADDR_W-1:0] : rd_base;
    assign lenq_room   = !lenq_full || release_fire;
    assign data_ok     = (rd_off < head_len);
    assign ram_raddr   = rd_base + rd_off[ADDR_W-1:0];

    // In IDLE wr_ptr always equals frm_start, so a sop byte is always placed at frm_start.
    assign byte_base = in_sop ? frm_start : wr_ptr;
    assign byte_used = byte_base - rd_base_eff;
    assign byte_full = (byte_used == ADDR_W'(DEPTH - 1));
    assign byte_len  = byte_base + ADDR_W'(1) - frm_start;
    assign mid_frame = (state != S_IDLE) || (in_valid && in_sop);

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        frm_start_n = frm_start;
        ram_we      = 1'b0;
        push        = 1'b0;
        push_len    = LEN_W'(byte_len);
        commit_inc  = 1'b0;
        drop_inc    = 1'b0;
        if (flush_fire) begin
            wr_ptr_n = frm_start;
            if (mid_frame && in_valid && in_eop) begin
                state_n  = S_IDLE;
                drop_inc = 1'b1;
            end else begin
                state_n = mid_frame ? S_DROP : S_IDLE;
            end
        end else if (in_valid) begin
            if (state == S_DROP && !in_sop) begin
                if (in_eop) begin
                    wr_ptr_n = frm_start;
                    state_n  = S_IDLE;
                    drop_inc = 1'b1;
                end
            end else if (state != S_IDLE || in_sop) begin
                if (byte_full) begin
                    if (in_eop) begin
                        wr_ptr_n = frm_start;
                        state_n  = S_IDLE;
                        drop_inc = 1'b1;
                    end else begin
                        state_n = S_DROP;
                    end
                end else begin
                    ram_we = 1'b1;
                    if (in_eop) begin
                        state_n = S_IDLE;
                        if (!in_err && lenq_room) begin
                            push        = 1'b1;
                            commit_inc  = 1'b1;
                            wr_ptr_n    = byte_base + ADDR_W'(1);
                            frm_start_n = byte_base + ADDR_W'(1);
                        end else begin
                            wr_ptr_n = frm_start;
                            drop_inc = 1'b1;
                        end
                    end else begin
                        wr_ptr_n = byte_base + ADDR_W'(1);
                        state_n  = S_RECV;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            frm_start <= '0;
            rd_base   <= '0;
            rd_off    <= '0;
            irq       <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            frm_start <= frm_start_n;
            rd_base   <= flush_fire ? frm_start : rd_base_eff;
            if (flush_fire || release_fire) rd_off <= '0;
            else if (data_rd && data_ok)    rd_off <= rd_off + LEN_W'(1);
            irq <= !lenq_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[byte_base] <= in_data;
        ram_q <= ram[ram_raddr];
    end

    eth_rx_len_fifo #(
        .DEPTH (LEN_FIFO_DEPTH),
        .W     (LEN_W)
    ) u_len_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_len),
        .pop       (release_fire),
        .flush     (flush_fire),
        .head      (lenq_head),
        .count     (lenq_count),
        .full      (lenq_full),
        .empty     (lenq_empty)
    );

    always_comb begin
        status_word = '0;
        if (!lenq_empty) begin
            status_word[STATUS_AVAIL_BIT]               = 1'b1;
            status_word[STATUS_CNT_MSB:STATUS_CNT_LSB]  = 3'(lenq_count);
            status_word[LEN_W-1:0]                      = lenq_head;
        end
        case (address)
            CSR_STATUS: csr_word = status_word;
            CSR_STATS:  csr_word = stats_word;
            default:    csr_word = '0;
        endcase
    end

`ifdef ETH_RX_BUF_STATS_EN
    logic [15:0] rx_frames, drop_frames;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_frames   <= '0;
            drop_frames <= '0;
        end else if (stats_wr) begin
            rx_frames   <= '0;
            drop_frames <= '0;
        end else begin
            if (commit_inc) rx_frames   <= sat_inc(rx_frames);
            if (drop_inc)   drop_frames <= sat_inc(drop_frames);
        end
    end

    assign stats_word = {rx_frames, drop_frames};
`else
    logic unused_stats;
    assign unused_stats = ^{commit_inc, drop_inc, stats_wr};
    assign stats_word   = '0;
`endif

    // readdata is only meaningful the cycle after a read and returns to 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_word_q <= '0;
            data_ok_q <= 1'b0;
        end else begin
            rd_word_q <= (rd_req && !data_rd) ? csr_word : '0;
            data_ok_q <= data_rd && data_ok;
        end
    end

    assign readdata = data_ok_q ? {{(32 - DATA_W){1'b0}}, ram_q} : rd_word_q;

endmodule

// File: tb/tb_eth_nios_v2_rx_frame_buf.sv
// Self-checking bench for eth_nios_v2_rx_frame_buf: frame vector table, hand-written corner
// sequences and random traffic checked against a queue-based frame model.
module tb_eth_nios_v2_rx_frame_buf;

    localparam int DEPTH = 512;
    localparam int QMAX  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_sop, in_eop, in_err;
    logic [7:0]  in_data;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata, readdata;
    logic        irq;

    always #5 clk = ~clk;

    eth_nios_v2_rx_frame_buf #(
        .DATA_W         (8),
        .ADDR_W         (9),
        .LEN_FIFO_DEPTH (QMAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_err     (in_err),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: committed bytes in arrival order plus the queue of frame lengths.
    logic [7:0] exp_q[$];
    int         len_q[$];
    int         rd_off_m;
    int         rx_m, drop_m;

    typedef struct {
        int          len;
        bit          err;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] model_status();
        if (len_q.size() == 0) return 32'h0;
        return {1'b1, 3'(len_q.size()), 12'h000, 16'(len_q[0])};
    endfunction

    function automatic logic [31:0] model_stats();
`ifdef ETH_RX_BUF_STATS_EN
        return {16'(rx_m), 16'(drop_m)};
`else
        return 32'h0;
`endif
    endfunction

    task automatic model_frame(input int len, input int start, input bit err);
        if (!err && len_q.size() < QMAX && exp_q.size() + len <= DEPTH - 1) begin
            for (int i = 0; i < len; i++) exp_q.push_back(8'(start + i));
            len_q.push_back(len);
            rx_m++;
        end else begin
            drop_m++;
        end
    endtask

    task automatic model_release();
        if (len_q.size() > 0) begin
            repeat (len_q[0]) void'(exp_q.pop_front());
            void'(len_q.pop_front());
            rd_off_m = 0;
        end
    endtask

    task automatic model_data(output logic [31:0] v);
        v = 32'h0;
        if (len_q.size() > 0 && rd_off_m < len_q[0]) begin
            v = {24'h0, exp_q[rd_off_m]};
            rd_off_m++;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        len_q.delete();
        rd_off_m = 0;
        rx_m     = 0;
        drop_m   = 0;
    endtask

    task automatic drive_frame(input int len, input int start, input bit err, input bit rel_on_eop);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(start + i);
            in_sop   = (i == 0);
            in_eop   = (i == len - 1);
            in_err   = err && (i == len - 1);
            if (rel_on_eop && i == len - 1) begin
                chipselect = 1'b1;
                write      = 1'b1;
                address    = 2'd2;
                writedata  = 32'h1;
            end
        end
        @(negedge clk);
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        in_eop     = 1'b0;
        in_err     = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
    endtask

    task automatic send_frame(input int len, input int start, input bit err);
        drive_frame(len, start, err, 1'b0);
        model_frame(len, start, err);
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        csr_read(2'd0, d);
        check(name, d, model_status());
        check({name, "_irq"}, 32'(irq), 32'(len_q.size() > 0));
    endtask

    task automatic check_stats(input string name);
        logic [31:0] d;
        csr_read(2'd3, d);
        check(name, d, model_stats());
    endtask

    task automatic stats_clear();
        csr_write(2'd3, 32'h0);
        rx_m   = 0;
        drop_m = 0;
    endtask

    task automatic read_bytes(input int n, input string name);
        logic [31:0] d, e;
        for (int i = 0; i < n; i++) begin
            model_data(e);
            csr_read(2'd1, d);
            check(name, d, e);
        end
    endtask

    task automatic release_head();
        csr_write(2'd2, 32'h1);
        model_release();
    endtask

    task automatic drain_head(input string name);
        int n;
        n = (len_q.size() > 0) ? len_q[0] - rd_off_m : 0;
        check_status({name, "_status"});
        read_bytes(n + 1, {name, "_data"});
        release_head();
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int          r;

        vecs[0] = '{64,  1'b0, 32'h9000_0040};
        vecs[1] = '{20,  1'b1, 32'h0000_0000};
        vecs[2] = '{1,   1'b0, 32'h9000_0001};
        vecs[3] = '{600, 1'b0, 32'h0000_0000};
        vecs[4] = '{60,  1'b0, 32'h9000_003C};
        vecs[5] = '{400, 1'b0, 32'h9000_0190};
        vecs[6] = '{511, 1'b0, 32'h9000_01FF};
        vecs[7] = '{512, 1'b0, 32'h0000_0000};
        vecs[8] = '{300, 1'b0, 32'h9000_012C};

        reset = 1'b1;
        in_valid = 1'b0; in_data = 8'h0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
        address = 2'd0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        check_status("rst_status");
        check_stats("rst_stats");

        // Table: each frame into an empty ring, then drained and released.
        for (int i = 0; i < 9; i++) begin
            if (i == 1) stats_clear();
            send_frame(vecs[i].len, i * 37, vecs[i].err);
            csr_read(2'd0, d);
            check($sformatf("vec%0d_status", i), d, vecs[i].exp_status);
            if (i == 1) check_stats("err_stats");
            drain_head($sformatf("vec%0d", i));
            check_status($sformatf("vec%0d_empty", i));
        end
        check_stats("table_stats");

        // Five frames against a four-deep length queue, then eop with a same-cycle release.
        for (int k = 0; k < 5; k++) send_frame(10, 8'h80 + k * 10, 1'b0);
        csr_read(2'd0, d);
        check("five_status", d, 32'hC000_000A);
        drive_frame(10, 8'hF0, 1'b0, 1'b1);
        model_release();
        model_frame(10, 8'hF0, 1'b0);
        csr_read(2'd0, d);
        check("eop_rel_status", d, 32'hC000_000A);
        for (int k = 0; k < 4; k++) drain_head("five_drain");
        check_stats("five_stats");

        // Flush together with release: flush wins and the queue empties.
        send_frame(30, 8'h11, 1'b0);
        send_frame(25, 8'h44, 1'b0);
        csr_write(2'd2, 32'h3);
        exp_q.delete();
        len_q.delete();
        rd_off_m = 0;
        csr_read(2'd0, d);
        check("flush_status", d, 32'h0);
        send_frame(17, 8'h90, 1'b0);
        drain_head("post_flush");

        // Reset in the middle of a frame at byte 30.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_sop   = (i == 0);
            in_eop   = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        reset    = 1'b0;
        csr_read(2'd0, d);
        check("midrst_status", d, 32'h0);
        check_stats("midrst_stats");
        send_frame(40, 8'hC0, 1'b0);
        drain_head("midrst_next");

        // 400-byte frame released, then a 300-byte frame wrapping the ring end.
        send_frame(400, 8'h00, 1'b0);
        drain_head("pre_wrap");
        send_frame(300, 8'h55, 1'b0);
        csr_read(2'd0, d);
        check("wrap_status", d, 32'h9000_012C);
        drain_head("wrap");

        // Random traffic against the model.
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                send_frame($urandom_range(1, 200), $urandom_range(0, 255), ($urandom_range(0, 15) == 0));
            end else if (r < 8) begin
                drain_head("rnd_drain");
            end else begin
                read_bytes($urandom_range(0, 5), "rnd_part");
                check_status("rnd_status");
                if ($urandom_range(0, 1) == 1) release_head();
            end
        end
        check_stats("rnd_stats");
        while (len_q.size() > 0) drain_head("final_drain");
        check_status("final_status");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
